// File: rtl/processor_switch_controller.sv
// Context-switch controller: grants one of NUM_PROC processors the shared buses and drains the owner before handing over.
// Optional recovery from the ERROR state is compiled in with `define ERROR_RECOVERY_EN.
module processor_switch_controller #(
  parameter int unsigned NUM_PROC      = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned BOOT_ID       = 0,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     IN_PB_RESET,
  input  logic [NUM_PROC-1:0]      switch_req,
  input  logic [NUM_PROC*ID_W-1:0] switch_target,
  input  logic [NUM_PROC-1:0]      fatal_error,
  input  logic [NUM_PROC-1:0]      proc_busy,
  input  logic                     error_clear,
  output logic [NUM_PROC-1:0]      proc_enable,
  output logic [ID_W-1:0]          proc_id,
  output logic                     switch_done,
  output logic                     error,
  output logic [ID_W-1:0]          error_proc,
  output logic [1:0]               error_cause
);

  localparam logic [2:0] ST_BOOT     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_HANDOVER = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_FATAL   = 2'd1;
  localparam logic [1:0] CAUSE_TARGET  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [ID_W-1:0] BOOT_SEL    = ID_W'(BOOT_ID);
  localparam logic [7:0]      TIMEOUT_VAL = 8'(DRAIN_TIMEOUT);
  localparam logic [ID_W:0]   PROC_LIMIT  = (ID_W+1)'(NUM_PROC);

  logic [2:0]      state, stateNext;
  logic [ID_W-1:0] curId, curIdNext;
  logic [ID_W-1:0] tgtId, tgtIdNext;
  logic [7:0]      drainCnt, drainCntNext;
  logic [ID_W-1:0] errProc, errProcNext;
  logic [1:0]      errCause, errCauseNext;

  logic            ownReq, ownFatal, ownBusy, clearReq;
  logic [ID_W-1:0] ownTarget;

  // Only the current owner's slice of each per-processor input is ever looked at.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    ownReq    = 1'b0;
    ownFatal  = 1'b0;
    ownBusy   = 1'b0;
    ownTarget = '0;
    for (int i = 0; i < int'(NUM_PROC); i++) begin
      if (curId == ID_W'(i)) begin
        ownReq    = switch_req[i];
        ownFatal  = fatal_error[i];
        ownBusy   = proc_busy[i];
        ownTarget = switch_target[i*ID_W +: ID_W];
      end
    end
  end

`ifdef ERROR_RECOVERY_EN
  assign clearReq = error_clear;
`else
  logic unusedClear;
  assign unusedClear = error_clear;
  assign clearReq    = 1'b0;
`endif

  always_comb begin
    stateNext    = state;
    curIdNext    = curId;
    tgtIdNext    = tgtId;
    drainCntNext = drainCnt;
    errProcNext  = errProc;
    errCauseNext = errCause;
    case (state)
      ST_BOOT: begin
        curIdNext = BOOT_SEL;
        stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (ownFatal) begin
          stateNext    = ST_ERROR;
          errProcNext  = curId;
          errCauseNext = CAUSE_FATAL;
        end else if (ownReq) begin
          if ({1'b0, ownTarget} >= PROC_LIMIT) begin
            stateNext    = ST_ERROR;
            errProcNext  = curId;
            errCauseNext = CAUSE_TARGET;
          end else if (ownTarget != curId) begin
            stateNext    = ST_DRAIN;
            tgtIdNext    = ownTarget;
            drainCntNext = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (ownFatal) begin
          stateNext    = ST_ERROR;
          errProcNext  = curId;
          errCauseNext = CAUSE_FATAL;
        end else if (!ownBusy) begin
          stateNext = ST_HANDOVER;
        end else if (drainCnt == TIMEOUT_VAL) begin
          stateNext    = ST_ERROR;
          errProcNext  = curId;
          errCauseNext = CAUSE_TIMEOUT;
        end else begin
          drainCntNext = drainCnt + 8'd1;
        end
      end
      ST_HANDOVER: begin
        curIdNext = tgtId;
        stateNext = ST_RUN;
      end
      ST_ERROR: begin
        if (clearReq) begin
          stateNext    = ST_BOOT;
          errProcNext  = '0;
          errCauseNext = CAUSE_NONE;
        end
      end
      default: stateNext = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      state    <= ST_BOOT;
      curId    <= BOOT_SEL;
      tgtId    <= '0;
      drainCnt <= '0;
      errProc  <= '0;
      errCause <= CAUSE_NONE;
    end else begin
      state    <= stateNext;
      curId    <= curIdNext;
      tgtId    <= tgtIdNext;
      drainCnt <= drainCntNext;
      errProc  <= errProcNext;
      errCause <= errCauseNext;
    end
  end

  // HANDOVER already steers the buses to the incoming owner while enables stay low.
  always_comb begin
    proc_enable = '0;
    for (int i = 0; i < int'(NUM_PROC); i++) begin
      proc_enable[i] = (state == ST_RUN) && (curId == ID_W'(i));
    end
  end

  assign proc_id     = (state == ST_HANDOVER) ? tgtId : curId;
  assign switch_done = (state == ST_HANDOVER);
  assign error       = (state == ST_ERROR);
  assign error_proc  = errProc;
  assign error_cause = errCause;

endmodule

// File: tb/tb_processor_switch_controller.sv
// Scoreboard bench: instance A (4 processors) and instance B (3 processors) run against a cycle model.
module tb_processor_switch_controller;

  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HAND = 3, M_ERR = 4;

  typedef struct {
    int st;
    int cur;
    int tgt;
    int cnt;
    int eproc;
    int ecause;
  } model_t;

  logic CLK = 1'b0;
  logic IN_PB_RESET = 1'b0;
  logic error_clear = 1'b0;

  logic [3:0] reqA = '0, fatA = '0, busyA = '0;
  logic [7:0] tgtA = '0;
  logic [3:0] enA;
  logic [1:0] idA, eprocA, causeA;
  logic       doneA, errA;

  logic [2:0] reqB = '0, fatB = '0, busyB = '0;
  logic [5:0] tgtB = '0;
  logic [2:0] enB;
  logic [1:0] idB, eprocB, causeB;
  logic       doneB, errB;

  int checks = 0;
  int errors = 0;
  model_t mA, mB;
  logic [11:0] expQ[$];

  always #5 CLK = ~CLK;

  processor_switch_controller #(.NUM_PROC(4), .ID_W(2), .BOOT_ID(0), .DRAIN_TIMEOUT(255)) dutA (
    .CLK(CLK), .IN_PB_RESET(IN_PB_RESET), .switch_req(reqA), .switch_target(tgtA),
    .fatal_error(fatA), .proc_busy(busyA), .error_clear(error_clear),
    .proc_enable(enA), .proc_id(idA), .switch_done(doneA), .error(errA),
    .error_proc(eprocA), .error_cause(causeA));

  processor_switch_controller #(.NUM_PROC(3), .ID_W(2), .BOOT_ID(0), .DRAIN_TIMEOUT(255)) dutB (
    .CLK(CLK), .IN_PB_RESET(IN_PB_RESET), .switch_req(reqB), .switch_target(tgtB),
    .fatal_error(fatB), .proc_busy(busyB), .error_clear(error_clear),
    .proc_enable(enB), .proc_id(idB), .switch_done(doneB), .error(errB),
    .error_proc(eprocB), .error_cause(causeB));

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got en=%b id=%0d done=%b err=%b eproc=%0d cause=%0d, want en=%b id=%0d done=%b err=%b eproc=%0d cause=%0d",
               tag, $time, obs[11:8], obs[7:6], obs[5], obs[4], obs[3:2], obs[1:0],
               exp[11:8], exp[7:6], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  function automatic model_t modelReset();
    model_t m;
    m.st = M_BOOT; m.cur = 0; m.tgt = 0; m.cnt = 0; m.eproc = 0; m.ecause = 0;
    return m;
  endfunction

  // Reference behaviour written from the controller's description, one clock edge per call.
  function automatic model_t modelStep(input model_t m, input int np, input logic [3:0] req,
                                       input logic [7:0] tgtv, input logic [3:0] fat,
                                       input logic [3:0] busy, input logic clr);
    model_t n = m;
    int t = int'(tgtv[m.cur*2 +: 2]);
    case (m.st)
      M_BOOT: begin n.st = M_RUN; n.cur = 0; end
      M_RUN: begin
        if (fat[m.cur]) begin n.st = M_ERR; n.eproc = m.cur; n.ecause = 1; end
        else if (req[m.cur] && t >= np) begin n.st = M_ERR; n.eproc = m.cur; n.ecause = 2; end
        else if (req[m.cur] && t != m.cur) begin n.st = M_DRAIN; n.tgt = t; n.cnt = 0; end
      end
      M_DRAIN: begin
        if (fat[m.cur]) begin n.st = M_ERR; n.eproc = m.cur; n.ecause = 1; end
        else if (!busy[m.cur]) n.st = M_HAND;
        else if (m.cnt == 255) begin n.st = M_ERR; n.eproc = m.cur; n.ecause = 3; end
        else n.cnt = m.cnt + 1;
      end
      M_HAND: begin n.st = M_RUN; n.cur = m.tgt; end
      default: begin
`ifdef ERROR_RECOVERY_EN
        if (clr) begin n.st = M_BOOT; n.eproc = 0; n.ecause = 0; end
`else
        if (clr) n.st = M_ERR;
`endif
      end
    endcase
    return n;
  endfunction

  function automatic logic [11:0] modelOut(input model_t m);
    logic [3:0] en = '0;
    logic [1:0] id = 2'(m.cur);
    if (m.st == M_RUN) en[m.cur] = 1'b1;
    if (m.st == M_HAND) id = 2'(m.tgt);
    return {en, id, m.st == M_HAND, m.st == M_ERR, 2'(m.eproc), 2'(m.ecause)};
  endfunction

  task automatic compareBoth();
    check("instA", {enA, idA, doneA, errA, eprocA, causeA}, expQ.pop_front());
    check("instB", {1'b0, enB, idB, doneB, errB, eprocB, causeB}, expQ.pop_front());
  endtask

  task automatic tick();
    mA = modelStep(mA, 4, reqA, tgtA, fatA, busyA, error_clear);
    mB = modelStep(mB, 3, {1'b0, reqB}, {2'b0, tgtB}, {1'b0, fatB}, {1'b0, busyB}, error_clear);
    expQ.push_back(modelOut(mA));
    expQ.push_back(modelOut(mB));
    @(posedge CLK);
    #1;
    compareBoth();
  endtask

  // Reset is asserted mid-cycle and must take effect without waiting for a clock edge.
  task automatic applyReset();
    reqA = '0; tgtA = '0; fatA = '0; busyA = '0;
    reqB = '0; tgtB = '0; fatB = '0; busyB = '0;
    error_clear = 1'b0;
    IN_PB_RESET = 1'b0;
    mA = modelReset();
    mB = modelReset();
    expQ.push_back(modelOut(mA));
    expQ.push_back(modelOut(mB));
    #1;
    compareBoth();
    @(posedge CLK);
    #1;
    expQ.push_back(modelOut(mA));
    expQ.push_back(modelOut(mB));
    compareBoth();
    IN_PB_RESET = 1'b1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    applyReset();
    repeat (3) tick();

    // Non-owner request and fault are ignored.
    reqA = 4'b0010; tgtA = 8'b11_11_11_11; fatA = 4'b0010;
    fatB = 3'b100;
    repeat (2) tick();
    reqA = '0; tgtA = '0; fatA = '0; fatB = '0;

    // P0 -> P2 with busy low: DRAIN, HANDOVER, RUN.
    reqA = 4'b0001; tgtA = 8'b00_00_00_10;
    tick();
    reqA = '0;
    repeat (3) tick();

    // Owner requesting itself is ignored.
    reqA = 4'b0100; tgtA = 8'b00_10_00_00;
    repeat (2) tick();
    reqA = '0;

    // P2 -> P1 with busy held through 10 DRAIN cycles.
    reqA = 4'b0100; tgtA = 8'b00_01_00_00; busyA = 4'b0100;
    tick();
    reqA = '0;
    repeat (10) tick();
    busyA = '0;
    repeat (3) tick();

    // P1 never drains: timeout error.
    reqA = 4'b0010; tgtA = 8'b00_00_00_00; busyA = 4'b0010;
    tick();
    reqA = '0;
    repeat (260) tick();
    busyA = '0;

    // Instance B: out-of-range target.
    reqB = 3'b001; tgtB = 6'b00_00_11;
    tick();
    reqB = '0; tgtB = '0;
    repeat (2) tick();

`ifdef ERROR_RECOVERY_EN
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    repeat (3) tick();
`else
    error_clear = 1'b1;
    repeat (3) tick();
    error_clear = 1'b0;
    repeat (100) tick();
`endif

    // Instance B: fault on owner.
    applyReset();
    repeat (2) tick();
    fatB = 3'b001;
    tick();
    fatB = '0;
    repeat (2) tick();

    // Fault during DRAIN on B, then reset A mid-DRAIN.
    applyReset();
    repeat (2) tick();
    reqA = 4'b0001; tgtA = 8'b00_00_00_11; busyA = 4'b0001;
    reqB = 3'b001;  tgtB = 6'b00_00_01;    busyB = 3'b001;
    tick();
    reqA = '0; reqB = '0;
    repeat (4) tick();
    fatB = 3'b001;
    repeat (2) tick();
    applyReset();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
